data_sram_responder: RTL and testbench
======================================

# data_sram_responder

Data-side memory responder for the five-stage MIPS pipeline: the slave end of the load/store interface that the datapath drives from its memory stage (address from `aluoutM`, store data from `writedataM`, load data returned into `readdataM`). It accepts one request at a time over a req/addr_ok/data_ok handshake. It holds a byte-writable word array and returns the response after a programmable number of wait cycles. The pipeline uses its handshake to stall the memory stage.

## Interface
- `DEPTH`, 1024: number of 32-bit words in the array (power of two).
- `LAT`, 1: cycles from acceptance to `data_ok`. Legal range 1..15.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset.
- `data_req` in 1: request valid.
- `data_wr` in 1: 1 = store, 0 = load.
- `data_wstrb` in 4: byte enables for stores; bit i writes byte i (`wdata[8i+7:8i]`). Ignored for loads.
- `data_addr` in 32: byte address. Word index = `data_addr[log2(DEPTH)+1:2]`; bits [1:0] ignored.
- `data_wdata` in 32: store data.
- `data_addr_ok` out 1: request accepted this cycle.
- `data_data_ok` out 1: response valid this cycle; one-cycle pulse.
- `data_rdata` out 32: load data, valid while `data_data_ok`=1.
- `data_err` out 1: present only with `DSRAM_ERR_EN` (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `data_addr_ok` = `data_req` (combinational). On an accepting edge, latch wr/wstrb/word index/wdata. Load the wait counter with `LAT-1`. Go to RESP if `LAT`=1, else go to WAIT.
- WAIT: decrement the counter each cycle. On the edge where the counter reaches 1, go to RESP. `data_addr_ok`=0.
- Commit rule: on the edge entering RESP, perform the access.
  - Store: write the strobed bytes of the latched word index.
  - Load: register `mem[index]` into `data_rdata`.
  - Strobe 4'b0000 store: no write, still completes.
- RESP: `data_data_ok`=1 and `data_addr_ok`=0. Return to IDLE on the next edge.
- Stores also drive `data_data_ok`. `data_rdata` then holds the pre-write word at the index.
- One outstanding request maximum. Request inputs are don't-care outside the accepting cycle.
- `data_rdata` holds its last value outside RESP.
- Array contents are not reset and are undefined at power-up.

## Timing
- Reset (`rst`=0 at an edge): state = IDLE, counter = 0, `data_addr_ok`=0 (forced), `data_data_ok`=0, `data_rdata`=32'h0, `data_err`=0.
- Reset during WAIT aborts the request and no write is committed. Reset during RESP suppresses `data_data_ok` from the next cycle. A write already committed on RESP entry stays.
- Latency: acceptance in cycle N gives `data_data_ok` in cycle N+LAT.
- Throughput: one request per LAT+1 cycles. The earliest next acceptance is cycle N+LAT+1.
- Read-after-write to the same address: a load accepted after the store's RESP returns the new data.
- Address wrap: indices beyond DEPTH alias modulo DEPTH (upper address bits ignored) unless `DSRAM_ERR_EN` is defined.

## Configuration
- Macro `DSRAM_ERR_EN`, defined:
  - Adds output `data_err`.
  - Out-of-range check: a request with any `data_addr` bits above `log2(DEPTH)+1` set is flagged.
  - Alignment check: a store whose strobe is not one of 0001, 0010, 0100, 1000, 0011, 1100 or 1111 is flagged.
  - Flagged requests complete normally with no write. Load data is 32'h0.
  - `data_err`=1 only in the RESP cycle of a flagged request.
- Not defined: no `data_err` port, no checks, addresses alias, and any strobe is honoured.

## Test plan
- Reset: drive `rst`=0 with `data_req`=1 → `data_addr_ok`=0, `data_data_ok`=0, `data_rdata`=0. Release reset → `data_addr_ok`=1 in the same cycle.
- Word store then load, LAT=1: store 0xDEADBEEF to 0x40 with strobe 1111. Then load 0x40 → first `data_data_ok` one cycle after acceptance. The load returns 0xDEADBEEF exactly LAT cycles after its acceptance.
- Byte strobes: store 0x11223344 to 0x80 with strobe 1111, then 0x000000AA with strobe 0001, then load 0x80 → 0x112233AA.
- LAT=4 with back-to-back requests: hold `data_req`=1 with three loads → acceptances are spaced 5 cycles apart. Each `data_data_ok` pulse lasts exactly 1 cycle.
- Reset mid-operation, LAT=4: accept a store of 0x55 to 0x10, then assert reset in the WAIT state. A later load of 0x10 returns the old value and no stray `data_data_ok` appears.
- With `DSRAM_ERR_EN`, DEPTH=1024: load 0x0000_1000 → `data_err`=1, `data_rdata`=0. Store with strobe 0110 → `data_err`=1 and memory unchanged. Without the macro, a load of 0x0000_1000 returns the word at 0x0.

Source files
------------

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: req/addr_ok/data_ok slave returning each response LAT cycles after acceptance.
// Define DSRAM_ERR_EN to add the data_err output with out-of-range and strobe-alignment checks.
module data_sram_responder #(
    parameter int DEPTH = 1024,
    parameter int LAT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata
`ifdef DSRAM_ERR_EN
    ,
    output logic        data_err
`endif
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state;
    logic [3:0]         waitCnt;
    logic               latWr;
    logic [3:0]         latStrb;
    logic [IDX_W-1:0]   latIdx;
    logic [31:0]        latWdata;
    logic               latErr;
    logic [31:0]        mem [DEPTH];

    logic               reqErr;
    logic               enterResp;
    logic               accWr;
    logic [3:0]         accStrb;
    logic [IDX_W-1:0]   accIdx;
    logic [31:0]        accWdata;
    logic               accErr;
    logic               unusedAddrBits;

`ifdef DSRAM_ERR_EN
    function automatic logic strbLegal(input logic [3:0] s);
        case (s)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: return 1'b1;
            default:                   return 1'b0;
        endcase
    endfunction

    assign reqErr = (|(data_addr >> (IDX_W + 2))) || (data_wr && !strbLegal(data_wstrb));
`else
    assign reqErr = 1'b0;
`endif

    // Only the word-index bits address the array; the rest alias away.
    assign unusedAddrBits = ^data_addr;

    assign data_addr_ok = rst && (state == IDLE) && data_req;

    // With LAT=1 the commit happens on the accepting edge, before the latches hold anything.
    assign enterResp = (LAT == 1) ? (state == IDLE && data_addr_ok)
                                  : (state == WAIT && waitCnt == 4'd1);
    assign accWr     = (state == IDLE) ? data_wr                : latWr;
    assign accStrb   = (state == IDLE) ? data_wstrb             : latStrb;
    assign accIdx    = (state == IDLE) ? data_addr[IDX_W+1:2]   : latIdx;
    assign accWdata  = (state == IDLE) ? data_wdata             : latWdata;
    assign accErr    = (state == IDLE) ? reqErr                 : latErr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            waitCnt      <= '0;
            data_data_ok <= 1'b0;
            data_rdata   <= '0;
        end else begin
            data_data_ok <= enterResp;
            if (enterResp)
                data_rdata <= accErr ? 32'h0 : mem[accIdx];
            case (state)
                IDLE: if (data_addr_ok) begin
                    waitCnt <= 4'(LAT - 1);
                    state   <= (LAT == 1) ? RESP : WAIT;
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (waitCnt == 4'd1)
                        state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && data_addr_ok) begin
            latWr    <= data_wr;
            latStrb  <= data_wstrb;
            latIdx   <= data_addr[IDX_W+1:2];
            latWdata <= data_wdata;
            latErr   <= reqErr;
        end
    end

    // Array is not reset; a reset cycle blocks a pending commit.
    always_ff @(posedge clk) begin
        if (rst && enterResp && accWr && !accErr) begin
            for (int b = 0; b < 4; b++)
                if (accStrb[b])
                    mem[accIdx][8*b +: 8] <= accWdata[8*b +: 8];
        end
    end

`ifdef DSRAM_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst)
            data_err <= 1'b0;
        else
            data_err <= enterResp && accErr;
    end
`endif

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: one LAT=1 and one LAT=4 instance sharing a request bus selected by sel.
// Error-check cases are exercised when DSRAM_ERR_EN is defined, address aliasing otherwise.
module tb_data_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic        sel = 1'b0;
    logic [3:0]  strb = 4'h0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;

    logic        req1, req4;
    logic        ok1, ok4, dok1, dok4;
    logic [31:0] rd1, rd4;
    logic        err1, err4;
    logic        addrOk, dataOk, errSig;
    logic [31:0] rdata;

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req1   = req & ~sel;
    assign req4   = req & sel;
    assign addrOk = sel ? ok4 : ok1;
    assign dataOk = sel ? dok4 : dok1;
    assign rdata  = sel ? rd4 : rd1;
    assign errSig = sel ? err4 : err1;

    data_sram_responder #(.DEPTH(1024), .LAT(1)) u1 (
        .clk(clk), .rst(rst), .data_req(req1), .data_wr(wr), .data_wstrb(strb),
        .data_addr(addr), .data_wdata(wdata), .data_addr_ok(ok1),
        .data_data_ok(dok1), .data_rdata(rd1)
`ifdef DSRAM_ERR_EN
        , .data_err(err1)
`endif
    );

    data_sram_responder #(.DEPTH(1024), .LAT(4)) u4 (
        .clk(clk), .rst(rst), .data_req(req4), .data_wr(wr), .data_wstrb(strb),
        .data_addr(addr), .data_wdata(wdata), .data_addr_ok(ok4),
        .data_data_ok(dok4), .data_rdata(rd4)
`ifdef DSRAM_ERR_EN
        , .data_err(err4)
`endif
    );

`ifndef DSRAM_ERR_EN
    assign err1 = 1'b0;
    assign err4 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            nPass++;
    endtask

    // One complete transaction; lat counts cycles from acceptance to data_ok.
    task automatic doReq(input logic s, input logic w, input logic [3:0] st,
                         input logic [31:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat, output logic er);
        int k;
        @(negedge clk);
        sel = s; req = 1'b1; wr = w; strb = st; addr = a; wdata = d;
        #1;
        k = 0;
        while (!addrOk && k < 20) begin
            @(negedge clk); #1; k++;
        end
        if (!addrOk) check("acceptTimeout", 32'd0, 32'd1);
        @(negedge clk);
        req = 1'b0; wr = 1'b0; strb = 4'h0; addr = 32'h0; wdata = 32'h0;
        lat = 1;
        while (!dataOk && lat < 20) begin
            @(negedge clk); lat++;
        end
        rd = rdata;
        er = errSig;
        if (!dataOk) begin
            check("respTimeout", 32'd0, 32'd1);
        end else begin
            @(negedge clk);
            check("pulseWidth", {31'd0, dataOk}, 32'd0);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [31:0] addrs [3];
        logic [31:0] expRd [3];
        int          accC [3];
        int          rspC [3];
        logic [31:0] rdv [3];
        int          na, nr, strays;
        logic        pend;

        // Reset with a request pending on both instances
        repeat (3) @(posedge clk);
        @(negedge clk);
        req = 1'b1; sel = 1'b0; #1;
        check("rstAddrOk1", {31'd0, addrOk}, 32'd0);
        check("rstDataOk1", {31'd0, dataOk}, 32'd0);
        check("rstRdata1", rdata, 32'h0);
        sel = 1'b1; #1;
        check("rstAddrOk4", {31'd0, addrOk}, 32'd0);
        check("rstRdata4", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b1; sel = 1'b0; #1;
        check("relAddrOk1", {31'd0, addrOk}, 32'd1);
        sel = 1'b1; #1;
        check("relAddrOk4", {31'd0, addrOk}, 32'd1);
        req = 1'b0;

        // Word store then load, LAT=1
        doReq(1'b0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF, rd, lat, er);
        check("stLat1", 32'(lat), 32'd1);
        doReq(1'b0, 1'b0, 4'hF, 32'h40, 32'h0, rd, lat, er);
        check("ldLat1", 32'(lat), 32'd1);
        check("ldWord", rd, 32'hDEADBEEF);

        // Byte strobes
        doReq(1'b0, 1'b1, 4'hF, 32'h80, 32'h11223344, rd, lat, er);
        doReq(1'b0, 1'b1, 4'h1, 32'h80, 32'h000000AA, rd, lat, er);
        check("stPreWrite", rd, 32'h11223344);
        doReq(1'b0, 1'b0, 4'h0, 32'h80, 32'h0, rd, lat, er);
        check("ldByte", rd, 32'h112233AA);
        doReq(1'b0, 1'b1, 4'h0, 32'h80, 32'hFFFFFFFF, rd, lat, er);
`ifdef DSRAM_ERR_EN
        check("zeroStrbErr", {31'd0, er}, 32'd1);
`else
        check("zeroStrbPre", rd, 32'h112233AA);
`endif
        doReq(1'b0, 1'b0, 4'h0, 32'h80, 32'h0, rd, lat, er);
        check("zeroStrbKeep", rd, 32'h112233AA);

        // LAT=4: preload, then three loads with req held
        addrs[0] = 32'h100; addrs[1] = 32'h104; addrs[2] = 32'h108;
        expRd[0] = 32'hA1A1A1A1; expRd[1] = 32'hB2B2B2B2; expRd[2] = 32'hC3C3C3C3;
        for (int i = 0; i < 3; i++)
            doReq(1'b1, 1'b1, 4'hF, addrs[i], expRd[i], rd, lat, er);
        check("stLat4", 32'(lat), 32'd4);
        na = 0; nr = 0; pend = 1'b0;
        for (int i = 0; i < 3; i++) begin accC[i] = 0; rspC[i] = 0; rdv[i] = 32'h0; end
        @(negedge clk);
        sel = 1'b1; req = 1'b1; wr = 1'b0; addr = addrs[0];
        for (int c = 0; c < 60 && nr < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (pend) begin
                pend = 1'b0;
                if (na == 3) req = 1'b0;
                else addr = addrs[na];
            end
            #1;
            if (dataOk) begin
                if (nr < 3) begin rspC[nr] = cyc; rdv[nr] = rdata; end
                nr++;
            end
            if (req && addrOk) begin
                if (na < 3) accC[na] = cyc;
                na++;
                pend = 1'b1;
            end
        end
        req = 1'b0;
        check("b2bCount", 32'(nr), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check("b2bLat", 32'(rspC[i] - accC[i]), 32'd4);
            check("b2bData", rdv[i], expRd[i]);
        end
        check("b2bSpace01", 32'(accC[1] - accC[0]), 32'd5);
        check("b2bSpace12", 32'(accC[2] - accC[1]), 32'd5);
        @(negedge clk); #1;
        check("b2bPulseEnd", {31'd0, dataOk}, 32'd0);

        // Reset during WAIT aborts the store
        doReq(1'b1, 1'b1, 4'hF, 32'h10, 32'h12345678, rd, lat, er);
        @(negedge clk);
        sel = 1'b1; req = 1'b1; wr = 1'b1; strb = 4'hF; addr = 32'h10; wdata = 32'h55;
        #1;
        for (int k = 0; k < 20 && !addrOk; k++) begin
            @(negedge clk); #1;
        end
        check("abortAccept", {31'd0, addrOk}, 32'd1);
        @(negedge clk);
        req = 1'b0; wr = 1'b0; rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        strays = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dataOk) strays++;
        end
        check("abortNoDataOk", 32'(strays), 32'd0);
        doReq(1'b1, 1'b0, 4'h0, 32'h10, 32'h0, rd, lat, er);
        check("abortOldData", rd, 32'h12345678);
        check("abortLdLat", 32'(lat), 32'd4);

        // Upper address bits: alias or flagged
        doReq(1'b0, 1'b1, 4'hF, 32'h0, 32'hCAFEF00D, rd, lat, er);
        doReq(1'b0, 1'b0, 4'h0, 32'h1000, 32'h0, rd, lat, er);
`ifdef DSRAM_ERR_EN
        check("oorErr", {31'd0, er}, 32'd1);
        check("oorRdata", rd, 32'h0);
        doReq(1'b0, 1'b1, 4'h6, 32'h40, 32'h0, rd, lat, er);
        check("alignErr", {31'd0, er}, 32'd1);
        doReq(1'b0, 1'b0, 4'h0, 32'h40, 32'h0, rd, lat, er);
        check("alignKeep", rd, 32'hDEADBEEF);
        check("okNoErr", {31'd0, er}, 32'd0);
`else
        check("aliasData", rd, 32'hCAFEF00D);
        check("aliasNoErr", {31'd0, er}, 32'd0);
`endif

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
